// File: rtl/pulp_clock_gate_req_ctrl.sv
// Requester side of the 4-phase enable handshake with a downstream synchronizing clock gate.
// Optional handshake watchdog is built when PULP_CLK_GATE_REQ_WDT_EN is defined.
module pulp_clock_gate_req_ctrl #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned IDLE_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic busy_i,
    output logic en_async_o,
    input  logic en_ack_async_i,
    output logic clk_ready_o,
    output logic err_o
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    if (SYNC_STAGES < 2 || IDLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pulp_clock_gate_req_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        OFF,
        WAKE,
        ON,
        IDLE,
        SLEEP
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic                   en_q, en_d;
    logic                   ready_q, ready_d;
    logic                   ack_s;
    logic                   active;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], en_ack_async_i};
    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign active = req_i | busy_i;

    // WAKE and SLEEP wait only on the acknowledge, so one level change is outstanding at a time.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            OFF: begin
                if (active) state_d = WAKE;
            end
            WAKE: begin
                if (ack_s) state_d = ON;
            end
            ON: begin
                if (!active) begin
                    state_d    = IDLE;
                    idle_cnt_d = IDLE_W'(1);
                end
            end
            IDLE: begin
                if (active) begin
                    state_d    = ON;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_MAX) begin
                    state_d    = SLEEP;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            SLEEP: begin
                if (!ack_s) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
        en_d    = (state_d == WAKE) || (state_d == ON) || (state_d == IDLE);
        ready_d = (state_d == ON) || (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= OFF;
            sync_q     <= '0;
            idle_cnt_q <= '0;
            en_q       <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            idle_cnt_q <= idle_cnt_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
        end
    end

    assign en_async_o  = en_q;
    assign clk_ready_o = ready_q;

`ifdef PULP_CLK_GATE_REQ_WDT_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT_CYCLES);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             err_q, err_d;

    // Counts cycles spent waiting on the gate; the FSM is never forced out, only flagged.
    always_comb begin
        wdt_d = '0;
        if (state_q == WAKE || state_q == SLEEP) begin
            wdt_d = (wdt_q == WDT_MAX) ? wdt_q : wdt_q + WDT_W'(1);
        end
        err_d = err_q | (wdt_d == WDT_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
